// File: rtl/cache_victim_ctrl.sv
// cache_victim_ctrl
//   Miss-handling controller for one set-associative cache. On an accepted
//   miss it snapshots the addressed set's valid/dirty bits and picks a victim:
//   the lowest-index invalid way, or a way chosen by an internal LFSR when
//   every way is valid. A dirty valid victim is written back first, then the
//   line is filled, then Done pulses for one cycle.
//
//   Optional build macro: CACHE_WAY_LOCK_EN adds a LockWay input. Locked ways
//   are never chosen. With every way locked, the miss completes without any
//   bus request and VictimWay is 0.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   FlushStage    pipeline flush (honoured in IDLE and SELECT only)
//   MissReq       miss request, sampled in IDLE
//   MissSet       set index of the miss
//   ValidWay      valid bits of the addressed set
//   DirtyWay      dirty bits of the addressed set
//   LockWay       lock bits of the addressed set (CACHE_WAY_LOCK_EN only)
//   WBAck         writeback complete
//   FillAck       fill complete
//   WBReq         writeback request, held until WBAck
//   FillReq       fill request, held until FillAck
//   VictimWay     one-hot victim, registered when SELECT is left
//   VictimSet     captured set index
//   Busy          high in every state except IDLE
//   Done          one-cycle completion pulse
module cache_victim_ctrl #(
  parameter int NUMWAYS  = 4,
  parameter int NUMLINES = 128,
  localparam int SETLEN  = $clog2(NUMLINES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              FlushStage,
  input  logic              MissReq,
  input  logic [SETLEN-1:0] MissSet,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [NUMWAYS-1:0] DirtyWay,
`ifdef CACHE_WAY_LOCK_EN
  input  logic [NUMWAYS-1:0] LockWay,
`endif
  input  logic              WBAck,
  input  logic              FillAck,
  output logic              WBReq,
  output logic              FillReq,
  output logic [NUMWAYS-1:0] VictimWay,
  output logic [SETLEN-1:0] VictimSet,
  output logic              Busy,
  output logic              Done
);

  localparam int WAYIDX  = $clog2(NUMWAYS);
  localparam int LFSRLEN = WAYIDX + 2;
  // Feedback tap paired with bit 0; gives a maximal-length sequence per width.
  localparam int TAPK    = (LFSRLEN == 5) ? 2 : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_WRITEBACK, S_FILL, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [SETLEN-1:0]    set_q, set_d;
  logic [NUMWAYS-1:0]   valid_q, valid_d;
  logic [NUMWAYS-1:0]   dirty_q, dirty_d;
  logic [NUMWAYS-1:0]   lock_q, lock_d;
  logic [NUMWAYS-1:0]   vict_q, vict_d;
  logic [LFSRLEN-1:0]   lfsr_q, lfsr_d;

  logic                 inv_found;
  logic [WAYIDX-1:0]    inv_idx;
  logic [WAYIDX-1:0]    rand_idx;
  logic [WAYIDX-1:0]    pick_idx;
  logic [WAYIDX-1:0]    victim_idx;
  logic                 all_locked;
  logic                 need_wb;
  logic [LFSRLEN-1:0]   lfsr_next;

  assign lfsr_next = {lfsr_q[0] ^ lfsr_q[TAPK], lfsr_q[LFSRLEN-1:1]};
  assign rand_idx  = lfsr_q[WAYIDX-1:0];

  // Victim selection over the captured snapshot.
  always_comb begin
    inv_found = 1'b0;
    inv_idx   = '0;
    // Descending scan so the lowest eligible invalid index wins.
    for (int i = NUMWAYS - 1; i >= 0; i--) begin
      if (!valid_q[i] && !lock_q[i]) begin
        inv_found = 1'b1;
        inv_idx   = WAYIDX'(i);
      end
    end
    // Random pick steps upward (wrapping) from the LFSR index past locked ways.
    pick_idx = rand_idx;
    for (int j = NUMWAYS - 1; j >= 0; j--) begin
      if (!lock_q[rand_idx + WAYIDX'(j)]) begin
        pick_idx = rand_idx + WAYIDX'(j);
      end
    end
    all_locked = &lock_q;
    victim_idx = inv_found ? inv_idx : pick_idx;
    need_wb    = valid_q[victim_idx] & dirty_q[victim_idx];
  end

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    lock_d  = lock_q;
    vict_d  = vict_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      S_IDLE: begin
        if (MissReq && !FlushStage) begin
          state_d = S_SELECT;
          set_d   = MissSet;
          valid_d = ValidWay;
          dirty_d = DirtyWay;
`ifdef CACHE_WAY_LOCK_EN
          lock_d  = LockWay;
`else
          lock_d  = '0;
`endif
        end
      end
      S_SELECT: begin
        if (FlushStage) begin
          state_d = S_IDLE;
        end else if (all_locked) begin
          state_d = S_DONE;
          vict_d  = '0;
        end else begin
          vict_d  = NUMWAYS'(1) << victim_idx;
          // LFSR only steps when it actually supplied the victim.
          if (!inv_found) begin
            lfsr_d = lfsr_next;
          end
          state_d = need_wb ? S_WRITEBACK : S_FILL;
        end
      end
      S_WRITEBACK: begin
        if (WBAck) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (FillAck) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      set_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      lock_q  <= '0;
      vict_q  <= '0;
      lfsr_q  <= LFSRLEN'(1);
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      lock_q  <= lock_d;
      vict_q  <= vict_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign WBReq     = (state_q == S_WRITEBACK);
  assign FillReq   = (state_q == S_FILL);
  assign Done      = (state_q == S_DONE);
  assign Busy      = (state_q != S_IDLE);
  assign VictimWay = vict_q;
  assign VictimSet = set_q;

endmodule

// File: tb/tb_cache_victim_ctrl.sv
// Directed bench for cache_victim_ctrl (NUMWAYS=4, NUMLINES=128, default build).
module tb_cache_victim_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       FlushStage;
  logic       MissReq;
  logic [6:0] MissSet;
  logic [3:0] ValidWay;
  logic [3:0] DirtyWay;
  logic       WBAck;
  logic       FillAck;
  logic       WBReq;
  logic       FillReq;
  logic [3:0] VictimWay;
  logic [6:0] VictimSet;
  logic       Busy;
  logic       Done;

  int tests = 0;
  int fails = 0;

  cache_victim_ctrl #(.NUMWAYS(4), .NUMLINES(128)) dut (
    .clk(clk), .reset(reset), .FlushStage(FlushStage), .MissReq(MissReq),
    .MissSet(MissSet), .ValidWay(ValidWay), .DirtyWay(DirtyWay),
    .WBAck(WBAck), .FillAck(FillAck), .WBReq(WBReq), .FillReq(FillReq),
    .VictimWay(VictimWay), .VictimSet(VictimSet), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] dirty;
    logic [6:0] set;
    int         wb_wait;
    logic [3:0] exp_way;
    logic       exp_wb;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference LFSR (4 bits, feedback bit0 ^ bit1 into the MSB).
  function automatic logic [3:0] lfsr_step(input logic [3:0] cur);
    return {cur[0] ^ cur[1], cur[3:1]};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    MissReq = 1'b0; FlushStage = 1'b0; WBAck = 1'b0; FillAck = 1'b0;
    MissSet = '0; ValidWay = '0; DirtyWay = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Full miss starting at a negedge with the DUT in IDLE; ends at a negedge in IDLE.
  task automatic run_miss(input logic [3:0] v, input logic [3:0] d, input logic [6:0] s,
                          input int wb_wait, input logic [3:0] exp_way, input logic exp_wb,
                          input string tag, output logic [3:0] got_way);
    check({tag, ".idle_busy"}, 32'(Busy), 32'd0);
    MissReq = 1'b1; ValidWay = v; DirtyWay = d; MissSet = s;
    @(negedge clk);                       // SELECT
    // Scramble inputs and raise acks that must all be ignored here.
    MissReq = 1'b0; ValidWay = ~v; DirtyWay = ~d; MissSet = ~s;
    WBAck = 1'b1; FillAck = 1'b1;
    check({tag, ".sel_busy"}, 32'(Busy), 32'd1);
    check({tag, ".sel_reqs"}, {30'd0, WBReq, FillReq}, 32'd0);
    @(negedge clk);                       // WRITEBACK or FILL
    WBAck = 1'b0; FillAck = 1'b0;
    got_way = VictimWay;
    check({tag, ".way"}, 32'(VictimWay), 32'(exp_way));
    check({tag, ".set"}, 32'(VictimSet), 32'(s));
    check({tag, ".wbreq"}, 32'(WBReq), 32'(exp_wb));
    check({tag, ".fillreq"}, 32'(FillReq), 32'(!exp_wb));
    check({tag, ".done_early"}, 32'(Done), 32'd0);
    if (exp_wb) begin
      for (int i = 1; i <= wb_wait; i++) begin
        check({tag, ".wb_hold"}, 32'(WBReq), 32'd1);
        if (i == wb_wait) WBAck = 1'b1;
        @(negedge clk);
      end
      WBAck = 1'b0;
      check({tag, ".wb_drop"}, {30'd0, WBReq, FillReq}, 32'd1);
    end
    FillAck = 1'b1;
    @(negedge clk);                       // DONE
    FillAck = 1'b0;
    check({tag, ".done"}, 32'(Done), 32'd1);
    check({tag, ".fill_drop"}, 32'(FillReq), 32'd0);
    @(negedge clk);                       // IDLE
    check({tag, ".done_pulse"}, {30'd0, Done, Busy}, 32'd0);
    $display("[TB] %s: set=%0d valid=%b dirty=%b victim=%b wb=%0d", tag, s, v, d, got_way, exp_wb);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] got;
    logic [3:0] first_way;
    logic [3:0] lfsr_m;

    // LFSR starts at 0001; hand-traced victims per vector.
    vecs[0] = '{4'b1011, 4'b1111, 7'd5,   0, 4'b0100, 1'b0}; // lowest invalid = way2
    vecs[1] = '{4'b1111, 4'b0010, 7'd9,   4, 4'b0010, 1'b1}; // lfsr 0001 -> idx1, dirty
    vecs[2] = '{4'b0000, 4'b1111, 7'd0,   0, 4'b0001, 1'b0};
    vecs[3] = '{4'b1110, 4'b0000, 7'd33,  0, 4'b0001, 1'b0};
    vecs[4] = '{4'b1111, 4'b0000, 7'd127, 0, 4'b0001, 1'b0}; // lfsr 1000 -> idx0
    vecs[5] = '{4'b0111, 4'b1111, 7'd64,  0, 4'b1000, 1'b0};
    vecs[6] = '{4'b1111, 4'b1111, 7'd12,  1, 4'b0001, 1'b1}; // lfsr 0100 -> idx0
    vecs[7] = '{4'b1111, 4'b0100, 7'd77,  2, 4'b0100, 1'b1}; // lfsr 0010 -> idx2
    vecs[8] = '{4'b1111, 4'b0010, 7'd3,   3, 4'b0010, 1'b1}; // lfsr 1001 -> idx1

    // Reset state.
    do_reset();
    check("reset.outs", {26'd0, WBReq, FillReq, Done, Busy, 2'd0}, 32'd0);
    check("reset.way", 32'(VictimWay), 32'd0);
    check("reset.set", 32'(VictimSet), 32'd0);

    // Table-driven misses.
    for (int i = 0; i < 9; i++) begin
      run_miss(vecs[i].valid, vecs[i].dirty, vecs[i].set, vecs[i].wb_wait,
               vecs[i].exp_way, vecs[i].exp_wb, $sformatf("vec%0d", i), got);
    end

    // Reset mid-handshake (in WRITEBACK).
    do_reset();
    MissReq = 1'b1; ValidWay = 4'b1111; DirtyWay = 4'b1111; MissSet = 7'd21;
    @(negedge clk);
    MissReq = 1'b0;
    @(negedge clk);
    check("midrst.wbreq_before", 32'(WBReq), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst.outs", {28'd0, WBReq, FillReq, Done, Busy}, 32'd0);
    check("midrst.way_set", {21'd0, VictimWay, VictimSet}, 32'd0);
    $display("[TB] midrst: reset applied during writeback");

    // FlushStage blocks acceptance in IDLE.
    MissReq = 1'b1; FlushStage = 1'b1; ValidWay = 4'b1111; DirtyWay = 4'b0000;
    @(negedge clk);
    check("flush_idle.busy", 32'(Busy), 32'd0);
    // Flush during SELECT.
    FlushStage = 1'b0;
    @(negedge clk);                       // SELECT
    MissReq = 1'b0; FlushStage = 1'b1;
    @(negedge clk);
    FlushStage = 1'b0;
    check("flush_sel.outs", {28'd0, WBReq, FillReq, Done, Busy}, 32'd0);
    check("flush_sel.way", 32'(VictimWay), 32'd0);
    $display("[TB] flush: miss dropped in SELECT");
    run_miss(4'b1111, 4'b0000, 7'd40, 0, 4'b0010, 1'b0, "after_flush", got);

    // LFSR sequence over 16 all-valid clean misses.
    do_reset();
    lfsr_m = 4'b0001;
    first_way = '0;
    for (int n = 0; n < 16; n++) begin
      run_miss(4'b1111, 4'b0000, 7'(n), 0, 4'b0001 << lfsr_m[1:0], 1'b0,
               $sformatf("lfsr%0d", n), got);
      if (n == 0) first_way = got;
      if (n == 15) check("lfsr.period", 32'(got), 32'(first_way));
      lfsr_m = lfsr_step(lfsr_m);
    end

    // MissReq and FillAck held high: IDLE, SELECT, FILL, DONE repeating.
    do_reset();
    MissReq = 1'b1; ValidWay = 4'b0000; DirtyWay = 4'b0000; FillAck = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("held.busy%0d", i), 32'(Busy), 32'((i % 4) != 3));
      check($sformatf("held.done%0d", i), 32'(Done), 32'((i % 4) == 2));
    end
    MissReq = 1'b0; FillAck = 1'b0;
    $display("[TB] held: 12 cycles with MissReq held high");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
